// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit bridging the execute stage to the DDR3 user interface
// Optional feature macro: MEM_ALIGN_CHK_EN (adds misalign_o and skips DDR traffic for misaligned H/W accesses)
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 29,
  parameter int DEST_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_store_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  input  logic [DEST_W-1:0]   req_dest_i,
  output logic                wb_valid_o,
  output logic [DEST_W-1:0]   wb_dest_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                mem_en_o,
  output logic [2:0]          mem_cmd_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_rdy_i,
  output logic                mem_wdf_wren_o,
  output logic [DATA_W-1:0]   mem_wdf_data_o,
  output logic [DATA_W/8-1:0] mem_wdf_mask_o,
  output logic                mem_wdf_end_o,
  input  logic                mem_wdf_rdy_i,
  input  logic [DATA_W-1:0]   mem_rd_data_i,
  input  logic                mem_rd_data_valid_i,
  input  logic                mem_rd_data_end_i
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic                misalign_o
`endif
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t state, state_n;

  logic              store_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [DEST_W-1:0] dest_r;
  logic              cmd_done_r;
  logic              wdf_done_r;
  logic [DATA_W-1:0] ld_data_r;

  logic              accept;
  logic              mis_req;
  logic              mis_flag;
  logic [LW-1:0]     lane;
  logic [LW-1:0]     lane_al;
  int                nbytes;
  logic [DATA_W-1:0] rd_shift;
  logic              fill;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] wr_rep;
  logic [NB-1:0]     wr_mask;
  logic              unused_rd_end;

  // Read completion is always single beat, so the end flag carries no information.
  assign unused_rd_end = mem_rd_data_end_i;

  assign accept = (state == IDLE) && req_valid_i;

`ifdef MEM_ALIGN_CHK_EN
  logic misalign_r;

  // A half on an odd address or a word off a 4-byte boundary is rejected without DDR traffic.
  always_comb begin
    mis_req = 1'b0;
    if (req_size_i == 2'b01)
      mis_req = req_addr_i[0];
    else if (req_size_i[1])
      mis_req = (req_addr_i[1:0] != 2'b00);
  end

  // Remember the misalignment verdict for the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_r <= 1'b0;
    else if (accept)
      misalign_r <= mis_req;
  end

  assign mis_flag   = misalign_r;
  assign misalign_o = (state == RESP) && misalign_r;
`else
  assign mis_req  = 1'b0;
  assign mis_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Request capture at acceptance, per-channel handshake tracking and load data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r    <= 1'b0;
      size_r     <= 2'b00;
      uns_r      <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      dest_r     <= '0;
      cmd_done_r <= 1'b0;
      wdf_done_r <= 1'b0;
      ld_data_r  <= '0;
    end else begin
      if (accept) begin
        store_r    <= req_store_i;
        size_r     <= req_size_i;
        uns_r      <= req_unsigned_i;
        addr_r     <= req_addr_i;
        data_r     <= req_data_i;
        dest_r     <= req_dest_i;
        cmd_done_r <= 1'b0;
        wdf_done_r <= 1'b0;
      end
      if (state == WR) begin
        if (mem_rdy_i)
          cmd_done_r <= 1'b1;
        if (mem_wdf_rdy_i)
          wdf_done_r <= 1'b1;
      end
      if ((state == RD_WAIT) && mem_rd_data_valid_i)
        ld_data_r <= ld_ext;
    end
  end

  // Lane selection, load extraction/extension and store replication/masking.
  always_comb begin
    lane     = addr_r[LW-1:0];
    lane_al  = lane;
    nbytes   = 4;
    rd_shift = '0;
    fill     = 1'b0;
    ld_ext   = '0;
    wr_rep   = '0;
    wr_mask  = '1;
    case (size_r)
      2'b00: begin
        lane_al = lane;
        nbytes  = 1;
      end
      2'b01: begin
        lane_al = lane & ~LW'(1);
        nbytes  = 2;
      end
      default: begin
        lane_al = lane & ~LW'(3);
        nbytes  = 4;
      end
    endcase
    rd_shift = mem_rd_data_i >> {lane_al, 3'b000};
    case (size_r)
      2'b00:   fill = ~uns_r & rd_shift[7];
      2'b01:   fill = ~uns_r & rd_shift[15];
      default: fill = ~uns_r & rd_shift[31];
    endcase
    for (int i = 0; i < DATA_W; i++)
      ld_ext[i] = (i < nbytes * 8) ? rd_shift[i] : fill;
    for (int i = 0; i < NB; i++) begin
      case (size_r)
        2'b00:   wr_rep[i*8 +: 8] = data_r[7:0];
        2'b01:   wr_rep[i*8 +: 8] = data_r[(i % 2)*8 +: 8];
        default: wr_rep[i*8 +: 8] = data_r[(i % 4)*8 +: 8];
      endcase
      wr_mask[i] = !((i >= int'(lane_al)) && (i < int'(lane_al) + nbytes));
    end
  end

  // Next-state logic and all state-derived outputs.
  always_comb begin
    state_n        = state;
    req_ready_o    = 1'b0;
    wb_valid_o     = 1'b0;
    wb_dest_o      = '0;
    wb_data_o      = '0;
    mem_en_o       = 1'b0;
    mem_cmd_o      = 3'b000;
    mem_addr_o     = '0;
    mem_wdf_wren_o = 1'b0;
    mem_wdf_data_o = '0;
    mem_wdf_mask_o = '0;
    case (state)
      IDLE: begin
        req_ready_o = rst_n;
        if (req_valid_i) begin
          if (mis_req)
            state_n = RESP;
          else if (req_store_i)
            state_n = WR;
          else
            state_n = RD_CMD;
        end
      end
      RD_CMD: begin
        mem_en_o   = 1'b1;
        mem_cmd_o  = 3'b001;
        mem_addr_o = addr_r & ~ADDR_W'(NB - 1);
        if (mem_rdy_i)
          state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rd_data_valid_i)
          state_n = RESP;
      end
      WR: begin
        mem_en_o       = !cmd_done_r;
        mem_addr_o     = addr_r & ~ADDR_W'(NB - 1);
        mem_wdf_wren_o = !wdf_done_r;
        mem_wdf_data_o = wr_rep;
        mem_wdf_mask_o = wr_mask;
        if ((cmd_done_r || mem_rdy_i) && (wdf_done_r || mem_wdf_rdy_i))
          state_n = RESP;
      end
      RESP: begin
        wb_valid_o = 1'b1;
        if (!store_r && !mis_flag) begin
          wb_dest_o = dest_r;
          wb_data_o = ld_data_r;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_wdf_end_o = mem_wdf_wren_o;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [28:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [4:0]  req_dest_i;
  logic        wb_valid_o;
  logic [4:0]  wb_dest_o;
  logic [31:0] wb_data_o;
  logic        mem_en_o;
  logic [2:0]  mem_cmd_o;
  logic [28:0] mem_addr_o;
  logic        mem_rdy_i;
  logic        mem_wdf_wren_o;
  logic [31:0] mem_wdf_data_o;
  logic [3:0]  mem_wdf_mask_o;
  logic        mem_wdf_end_o;
  logic        mem_wdf_rdy_i;
  logic [31:0] mem_rd_data_i;
  logic        mem_rd_data_valid_i;
  logic        mem_rd_data_end_i;
`ifdef MEM_ALIGN_CHK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_store_i         (req_store_i),
    .req_size_i          (req_size_i),
    .req_unsigned_i      (req_unsigned_i),
    .req_addr_i          (req_addr_i),
    .req_data_i          (req_data_i),
    .req_dest_i          (req_dest_i),
    .wb_valid_o          (wb_valid_o),
    .wb_dest_o           (wb_dest_o),
    .wb_data_o           (wb_data_o),
    .mem_en_o            (mem_en_o),
    .mem_cmd_o           (mem_cmd_o),
    .mem_addr_o          (mem_addr_o),
    .mem_rdy_i           (mem_rdy_i),
    .mem_wdf_wren_o      (mem_wdf_wren_o),
    .mem_wdf_data_o      (mem_wdf_data_o),
    .mem_wdf_mask_o      (mem_wdf_mask_o),
    .mem_wdf_end_o       (mem_wdf_end_o),
    .mem_wdf_rdy_i       (mem_wdf_rdy_i),
    .mem_rd_data_i       (mem_rd_data_i),
    .mem_rd_data_valid_i (mem_rd_data_valid_i),
    .mem_rd_data_end_i   (mem_rd_data_end_i)
`ifdef MEM_ALIGN_CHK_EN
    ,
    .misalign_o          (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic present(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [28:0] addr, input logic [31:0] data, input logic [4:0] dest);
    req_valid_i    = 1'b1;
    req_store_i    = st;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_data_i     = data;
    req_dest_i     = dest;
  endtask

  // Zero-wait-state load: accept, command, read data, writeback.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [28:0] addr, input logic [4:0] dest,
                         input logic [31:0] rdata, input logic [31:0] exp_data,
                         input logic [28:0] exp_addr);
    present(1'b0, sz, uns, addr, 32'h0, dest);
    mem_rdy_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk({tag, "_en"}, {31'b0, mem_en_o}, 32'd1);
    chk({tag, "_cmd"}, {29'b0, mem_cmd_o}, 32'd1);
    chk({tag, "_addr"}, {3'b0, mem_addr_o}, {3'b0, exp_addr});
    chk({tag, "_rdy_busy"}, {31'b0, req_ready_o}, 32'd0);
    tick();
    mem_rd_data_i       = rdata;
    mem_rd_data_valid_i = 1'b1;
    tick();
    mem_rd_data_valid_i = 1'b0;
    chk({tag, "_wbv"}, {31'b0, wb_valid_o}, 32'd1);
    chk({tag, "_data"}, wb_data_o, exp_data);
    chk({tag, "_dest"}, {27'b0, wb_dest_o}, {27'b0, dest});
    tick();
    chk({tag, "_idle"}, {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_store_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_data_i = '0; req_dest_i = '0;
    mem_rdy_i = 1'b0; mem_wdf_rdy_i = 1'b0; mem_rd_data_i = '0;
    mem_rd_data_valid_i = 1'b0; mem_rd_data_end_i = 1'b0;

    // Reset state
    tick();
    chk("rst_ready", {31'b0, req_ready_o}, 32'd0);
    chk("rst_wbv", {31'b0, wb_valid_o}, 32'd0);
    chk("rst_en", {31'b0, mem_en_o}, 32'd0);
    chk("rst_wren", {31'b0, mem_wdf_wren_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {31'b0, req_ready_o}, 32'd1);

    // Loads with sign/zero extension
    do_load("ldb_s", 2'b00, 1'b0, 29'h103, 5'd7, 32'h8000_0000, 32'hFFFF_FF80, 29'h100);
    do_load("ldh_u", 2'b01, 1'b1, 29'h102, 5'd9, 32'hBEEF_1234, 32'h0000_BEEF, 29'h100);
    do_load("ldh_s", 2'b01, 1'b0, 29'h102, 5'd9, 32'hBEEF_1234, 32'hFFFF_BEEF, 29'h100);
    do_load("ldw_fa", 2'b10, 1'b0, 29'h100, 5'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, 29'h100);
    do_load("ldb_u", 2'b00, 1'b1, 29'h101, 5'd2, 32'h0000_9A00, 32'h0000_009A, 29'h100);
    do_load("ldh_lo", 2'b01, 1'b0, 29'h200, 5'd4, 32'h1111_7FFE, 32'h0000_7FFE, 29'h200);
`ifndef MEM_ALIGN_CHK_EN
    // Misaligned accesses are forced aligned without the check feature
    do_load("ldw_mis", 2'b10, 1'b0, 29'h102, 5'd5, 32'h1234_5678, 32'h1234_5678, 29'h100);
    do_load("ldh_mis", 2'b11, 1'b1, 29'h103, 5'd6, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 29'h100);
`endif

    // ST.B with write-data channel stalled three cycles
    present(1'b1, 2'b00, 1'b0, 29'h101, 32'h0000_00A5, 5'd12);
    mem_rdy_i = 1'b1;
    mem_wdf_rdy_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    chk("stb_en", {31'b0, mem_en_o}, 32'd1);
    chk("stb_cmd", {29'b0, mem_cmd_o}, 32'd0);
    chk("stb_addr", {3'b0, mem_addr_o}, 32'h100);
    chk("stb_mask", {28'b0, mem_wdf_mask_o}, 32'b1101);
    chk("stb_wdata", mem_wdf_data_o, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      chk("stb_wren_hold", {31'b0, mem_wdf_wren_o}, 32'd1);
      chk("stb_end_hold", {31'b0, mem_wdf_end_o}, 32'd1);
      chk("stb_ready_low", {31'b0, req_ready_o}, 32'd0);
      chk("stb_no_wbv", {31'b0, wb_valid_o}, 32'd0);
      tick();
      chk("stb_en_dropped", {31'b0, mem_en_o}, 32'd0);
    end
    mem_wdf_rdy_i = 1'b1;
    tick();
    chk("stb_wren_off", {31'b0, mem_wdf_wren_o}, 32'd0);
    chk("stb_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("stb_dest", {27'b0, wb_dest_o}, 32'd0);
    chk("stb_wbdata", wb_data_o, 32'd0);
    tick();
    chk("stb_idle", {31'b0, req_ready_o}, 32'd1);

    // ST.H: command stalled, data accepted first
    present(1'b1, 2'b01, 1'b0, 29'h302, 32'hFFFF_1234, 5'd3);
    mem_rdy_i = 1'b0;
    mem_wdf_rdy_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk("sth_mask", {28'b0, mem_wdf_mask_o}, 32'b0011);
    chk("sth_wdata", mem_wdf_data_o, 32'h1234_1234);
    tick();
    chk("sth_wren_off", {31'b0, mem_wdf_wren_o}, 32'd0);
    chk("sth_en_held", {31'b0, mem_en_o}, 32'd1);
    mem_rdy_i = 1'b1;
    tick();
    chk("sth_wbv", {31'b0, wb_valid_o}, 32'd1);
    tick();

    // ST.W: full-word mask
    present(1'b1, 2'b10, 1'b0, 29'h404, 32'hDEAD_BEEF, 5'd0);
    tick();
    req_valid_i = 1'b0;
    chk("stw_mask", {28'b0, mem_wdf_mask_o}, 32'b0000);
    chk("stw_wdata", mem_wdf_data_o, 32'hDEAD_BEEF);
    tick();
    chk("stw_wbv", {31'b0, wb_valid_o}, 32'd1);
    tick();

    // Stray read data while idle, then load with command stalled five cycles
    mem_rd_data_i = 32'hDEAD_BEEF;
    mem_rd_data_valid_i = 1'b1;
    tick();
    chk("stray_idle_wbv", {31'b0, wb_valid_o}, 32'd0);
    chk("stray_idle_ready", {31'b0, req_ready_o}, 32'd1);
    mem_rd_data_valid_i = 1'b0;
    present(1'b0, 2'b10, 1'b0, 29'h200, 32'h0, 5'd3);
    mem_rdy_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    mem_rd_data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("ldst_en_held", {31'b0, mem_en_o}, 32'd1);
      chk("ldst_cmd_held", {29'b0, mem_cmd_o}, 32'd1);
      tick();
    end
    mem_rd_data_valid_i = 1'b0;
    mem_rdy_i = 1'b1;
    tick();
    chk("ldst_en_off", {31'b0, mem_en_o}, 32'd0);
    tick();
    chk("ldst_wait_wbv", {31'b0, wb_valid_o}, 32'd0);
    mem_rd_data_i = 32'h1122_3344;
    mem_rd_data_valid_i = 1'b1;
    tick();
    mem_rd_data_valid_i = 1'b0;
    chk("ldst_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("ldst_data", wb_data_o, 32'h1122_3344);
    chk("ldst_dest", {27'b0, wb_dest_o}, 32'd3);
    tick();

    // Reset while waiting for read data; late data must be discarded
    present(1'b0, 2'b10, 1'b0, 29'h500, 32'h0, 5'd8);
    mem_rdy_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", {31'b0, req_ready_o}, 32'd0);
    chk("rstmid_en", {31'b0, mem_en_o}, 32'd0);
    mem_rd_data_i = 32'h5555_AAAA;
    mem_rd_data_valid_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_wbv", {31'b0, wb_valid_o}, 32'd0);
    chk("rstmid_idle", {31'b0, req_ready_o}, 32'd1);
    tick();
    chk("rstmid_wbv2", {31'b0, wb_valid_o}, 32'd0);
    mem_rd_data_valid_i = 1'b0;
    do_load("ld_after_rst", 2'b00, 1'b1, 29'h001, 5'd10, 32'h0000_AB00, 32'h0000_00AB, 29'h000);

`ifdef MEM_ALIGN_CHK_EN
    // Misaligned word: no DDR traffic, immediate flagged response
    present(1'b0, 2'b10, 1'b0, 29'h102, 32'h0, 5'd11);
    mem_rdy_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk("mis_en", {31'b0, mem_en_o}, 32'd0);
    chk("mis_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("mis_flag", {31'b0, misalign_o}, 32'd1);
    chk("mis_dest", {27'b0, wb_dest_o}, 32'd0);
    chk("mis_data", wb_data_o, 32'd0);
    tick();
    chk("mis_flag_off", {31'b0, misalign_o}, 32'd0);
    chk("mis_idle", {31'b0, req_ready_o}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
